// File: rtl/risc16_mem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | risc16_mem_pkg : shared IDs and default widths for the arbiter    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package risc16_mem_pkg;

   localparam int c_addr_w = 16;
   localparam int c_data_w = 16;

   localparam logic [1:0] REQ_NONE = 2'd0;
   localparam logic [1:0] REQ_IF   = 2'd1;
   localparam logic [1:0] REQ_DM   = 2'd2;
   localparam logic [1:0] REQ_LD   = 2'd3;

   // Grant vectors are ordered {LD, DM, IF}.
   function automatic logic [1:0] gnt_to_id(input logic [2:0] gnt);
      logic [1:0] id;
      id = REQ_NONE;
      if (gnt[2])      id = REQ_LD;
      else if (gnt[1]) id = REQ_DM;
      else if (gnt[0]) id = REQ_IF;
      return id;
   endfunction

endpackage
`default_nettype wire

// File: rtl/risc16_mem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | risc16_mem_arbiter_if : requester and RAM side bundle             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface risc16_mem_arbiter_if
   import risc16_mem_pkg::*;
#(
   parameter int P_ADDR_W = c_addr_w,
   parameter int P_DATA_W = c_data_w
);
   logic                i_if_req;
   logic [P_ADDR_W-1:0] i_if_addr;
   logic                o_if_gnt;
   logic                o_if_rvalid;

   logic                i_dm_req;
   logic                i_dm_we;
   logic [P_ADDR_W-1:0] i_dm_addr;
   logic [P_DATA_W-1:0] i_dm_wdata;
   logic                o_dm_gnt;
   logic                o_dm_rvalid;

   logic                i_ld_req;
   logic                i_ld_we;
   logic [P_ADDR_W-1:0] i_ld_addr;
   logic [P_DATA_W-1:0] i_ld_wdata;
   logic                o_ld_gnt;
   logic                o_ld_rvalid;

   logic [P_DATA_W-1:0] o_rsp_data;

   logic                o_ram_en;
   logic                o_ram_we;
   logic [P_ADDR_W-1:0] o_ram_addr;
   logic [P_DATA_W-1:0] o_ram_wdata;
   logic [P_DATA_W-1:0] i_ram_rdata;

   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_gnt, o_if_rvalid,
      input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
      output o_dm_gnt, o_dm_rvalid,
      input  i_ld_req, i_ld_we, i_ld_addr, i_ld_wdata,
      output o_ld_gnt, o_ld_rvalid,
      output o_rsp_data,
      output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
      input  i_ram_rdata
   );

   modport master (
      output i_if_req, i_if_addr,
      input  o_if_gnt, o_if_rvalid,
      output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
      input  o_dm_gnt, o_dm_rvalid,
      output i_ld_req, i_ld_we, i_ld_addr, i_ld_wdata,
      input  o_ld_gnt, o_ld_rvalid,
      input  o_rsp_data,
      input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
      output i_ram_rdata
   );

endinterface
`default_nettype wire

// File: rtl/risc16_mem_arbiter_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | risc16_arb_pick : 3-way request -> one-hot grant ({LD,DM,IF})     |
// | RISC16_MEM_ARB_RR_EN selects round-robin, else fixed + starvation |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module risc16_arb_pick
   import risc16_mem_pkg::*;
(
   input  logic [2:0] i_req,
`ifdef RISC16_MEM_ARB_RR_EN
   input  logic [1:0] i_ptr,
`else
   input  logic [2:0] i_starved,
`endif
   output logic [2:0] o_gnt
);

`ifdef RISC16_MEM_ARB_RR_EN

   // Search starts one step past the last winner on the ring IF->DM->LD->IF.
   always_comb begin
      o_gnt = 3'b000;
      case (i_ptr)
         REQ_DM: begin
            if (i_req[2])      o_gnt = 3'b100;
            else if (i_req[0]) o_gnt = 3'b001;
            else if (i_req[1]) o_gnt = 3'b010;
         end
         REQ_LD: begin
            if (i_req[0])      o_gnt = 3'b001;
            else if (i_req[1]) o_gnt = 3'b010;
            else if (i_req[2]) o_gnt = 3'b100;
         end
         default: begin
            if (i_req[1])      o_gnt = 3'b010;
            else if (i_req[2]) o_gnt = 3'b100;
            else if (i_req[0]) o_gnt = 3'b001;
         end
      endcase
   end

`else

   logic [2:0] w_hot;
   logic [2:0] w_sel;

   // Starved requesters form their own pool; fixed priority breaks ties.
   assign w_hot = i_req & i_starved;
   assign w_sel = (|w_hot) ? w_hot : i_req;

   always_comb begin
      o_gnt = 3'b000;
      if (w_sel[2])      o_gnt = 3'b100;
      else if (w_sel[1]) o_gnt = 3'b010;
      else if (w_sel[0]) o_gnt = 3'b001;
   end

`endif

endmodule
`default_nettype wire

// File: rtl/risc16_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | risc16_mem_arbiter : IF/DM/LD share one single-port 16-bit RAM    |
// | Option: RISC16_MEM_ARB_RR_EN (round-robin, no starvation counters)|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module risc16_mem_arbiter
   import risc16_mem_pkg::*;
#(
   parameter int P_ADDR_W   = c_addr_w,
   parameter int P_DATA_W   = c_data_w,
   parameter int P_MAX_WAIT = 8
)(
   input  logic                 i_clk,
   input  logic                 i_rst,
   risc16_mem_arbiter_if.slave  bus
);

   logic                r_rst_d;
   logic [1:0]          r_owner;
   logic                w_block;
   logic [2:0]          w_raw;
   logic [2:0]          w_req;
   logic [2:0]          w_gnt;
   logic                w_ram_we;
   logic [P_ADDR_W-1:0] w_ram_addr;
   logic [P_DATA_W-1:0] w_ram_wdata;
   logic                w_rv_if;
   logic                w_rv_dm;
   logic                w_rv_ld;

   // Grants stay off during reset and for the cycle that follows it.
   assign w_block = i_rst | r_rst_d;
   assign w_raw   = {bus.i_ld_req, bus.i_dm_req, bus.i_if_req};
   assign w_req   = w_raw & {3{~w_block}};

`ifdef RISC16_MEM_ARB_RR_EN

   logic [1:0] r_ptr;

   risc16_arb_pick u_pick (
      .i_req (w_req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_ptr <= REQ_IF;
      else if (|w_gnt)
         r_ptr <= gnt_to_id(w_gnt);
   end

`else

   localparam logic [7:0] c_max_wait = 8'(P_MAX_WAIT);

   logic [2:0] w_starved;

   risc16_arb_pick u_pick (
      .i_req     (w_req),
      .i_starved (w_starved),
      .o_gnt     (w_gnt)
   );

   for (genvar gi = 0; gi < 3; gi++) begin : g_wait
      logic [7:0] r_cnt;

      always_ff @(posedge i_clk) begin
         if (i_rst || !w_raw[gi] || w_gnt[gi])
            r_cnt <= 8'd0;
         else if (r_cnt < c_max_wait)
            r_cnt <= r_cnt + 8'd1;
      end

      assign w_starved[gi] = (r_cnt >= c_max_wait);
   end

`endif

   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_addr  = '0;
      w_ram_wdata = '0;
      if (w_gnt[2]) begin
         w_ram_we    = bus.i_ld_we;
         w_ram_addr  = bus.i_ld_addr;
         w_ram_wdata = bus.i_ld_wdata;
      end else if (w_gnt[1]) begin
         w_ram_we    = bus.i_dm_we;
         w_ram_addr  = bus.i_dm_addr;
         w_ram_wdata = bus.i_dm_wdata;
      end else if (w_gnt[0]) begin
         w_ram_addr  = bus.i_if_addr;
      end
   end

   assign bus.o_ram_en    = |w_gnt;
   assign bus.o_ram_we    = w_ram_we;
   assign bus.o_ram_addr  = w_ram_addr;
   assign bus.o_ram_wdata = w_ram_wdata;

   assign bus.o_if_gnt = w_gnt[0];
   assign bus.o_dm_gnt = w_gnt[1];
   assign bus.o_ld_gnt = w_gnt[2];

   always_ff @(posedge i_clk) begin
      r_rst_d <= i_rst;
      if (i_rst)
         r_owner <= REQ_NONE;
      else if ((|w_gnt) && !w_ram_we)
         r_owner <= gnt_to_id(w_gnt);
      else
         r_owner <= REQ_NONE;
   end

   // A response pending when reset rises is dropped, not delivered.
   assign w_rv_if = (r_owner == REQ_IF) && !i_rst;
   assign w_rv_dm = (r_owner == REQ_DM) && !i_rst;
   assign w_rv_ld = (r_owner == REQ_LD) && !i_rst;

   assign bus.o_if_rvalid = w_rv_if;
   assign bus.o_dm_rvalid = w_rv_dm;
   assign bus.o_ld_rvalid = w_rv_ld;
   assign bus.o_rsp_data  = (w_rv_if | w_rv_dm | w_rv_ld) ? bus.i_ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_risc16_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_risc16_mem_arbiter : random + directed bench with ref model    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_risc16_mem_arbiter;
   import risc16_mem_pkg::*;

   localparam int MAXW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   risc16_mem_arbiter_if #(.P_ADDR_W(16), .P_DATA_W(16)) bus ();

   risc16_mem_arbiter #(.P_ADDR_W(16), .P_DATA_W(16), .P_MAX_WAIT(MAXW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Environment RAM: write-before-read, one-cycle read latency.
   logic [15:0] ram [0:65535];
   always @(posedge clk) begin
      if (bus.o_ram_en) begin
         if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_wdata;
         else              bus.i_ram_rdata     <= ram[bus.o_ram_addr];
      end
   end

   int n_tot = 0;
   int n_bad = 0;

   bit          rq_act [3];
   bit          rq_we  [3];
   logic [15:0] rq_addr[3];
   logic [15:0] rq_wd  [3];

   logic [15:0] model_mem [0:65535];
   int          m_wait[3];
   int          m_ptr;
   int          m_owner;
   logic [15:0] m_rdat;
   bit          m_rst_prev;

   logic [2:0]  obs_g;
   logic [2:0]  obs_rv;
   logic [15:0] obs_rsp;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive();
      bus.i_if_req   = rq_act[0];
      bus.i_if_addr  = rq_addr[0];
      bus.i_dm_req   = rq_act[1];
      bus.i_dm_we    = rq_we[1];
      bus.i_dm_addr  = rq_addr[1];
      bus.i_dm_wdata = rq_wd[1];
      bus.i_ld_req   = rq_act[2];
      bus.i_ld_we    = rq_we[2];
      bus.i_ld_addr  = rq_addr[2];
      bus.i_ld_wdata = rq_wd[2];
   endtask

   task automatic post(input int who, input bit we, input logic [15:0] a, input logic [15:0] d);
      rq_act[who]  = 1'b1;
      rq_we[who]   = (who == 0) ? 1'b0 : we;
      rq_addr[who] = a;
      rq_wd[who]   = (who == 0) ? 16'h0 : d;
      drive();
   endtask

   // Reference: decide the winner from the arbitration rules, predict all outputs.
   task automatic model_check();
      int          g;
      bit          blk;
      logic [2:0]  eg;
      logic [2:0]  erv;
      bit          e_we;
      logic [15:0] e_addr;
      logic [15:0] e_wd;
      g   = -1;
      blk = rst || m_rst_prev;
      if (!blk) begin
`ifdef RISC16_MEM_ARB_RR_EN
         for (int k = 1; k <= 3; k++)
            if (g < 0 && rq_act[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
`else
         for (int i = 2; i >= 0; i--)
            if (g < 0 && rq_act[i] && m_wait[i] >= MAXW) g = i;
         for (int i = 2; i >= 0; i--)
            if (g < 0 && rq_act[i]) g = i;
`endif
      end
      eg = (g < 0) ? 3'b000 : 3'(1 << g);
      e_we = 1'b0; e_addr = 16'h0; e_wd = 16'h0;
      if (g >= 0) begin
         e_we = rq_we[g]; e_addr = rq_addr[g]; e_wd = rq_wd[g];
      end
      erv = (!rst && m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;

      obs_g   = {bus.o_ld_gnt, bus.o_dm_gnt, bus.o_if_gnt};
      obs_rv  = {bus.o_ld_rvalid, bus.o_dm_rvalid, bus.o_if_rvalid};
      obs_rsp = bus.o_rsp_data;

      check("gnt",       32'(obs_g), 32'(eg));
      check("ram_en",    32'(bus.o_ram_en), 32'(g >= 0));
      check("ram_we",    32'(bus.o_ram_we), 32'(e_we));
      check("ram_addr",  32'(bus.o_ram_addr), 32'(e_addr));
      check("ram_wdata", 32'(bus.o_ram_wdata), 32'(e_wd));
      check("rvalid",    32'(obs_rv), 32'(erv));
      check("rsp_data",  32'(obs_rsp), (erv != 3'b000) ? 32'(m_rdat) : 32'h0);

      if (rst) begin
         m_wait  = '{0, 0, 0};
         m_ptr   = 0;
         m_owner = -1;
      end else begin
         m_owner = -1;
         if (g >= 0) begin
            if (rq_we[g]) model_mem[rq_addr[g]] = rq_wd[g];
            else begin
               m_owner = g;
               m_rdat  = model_mem[rq_addr[g]];
            end
            m_ptr = g;
         end
         for (int i = 0; i < 3; i++)
            m_wait[i] = (!rq_act[i] || g == i) ? 0 : ((m_wait[i] + 1 > MAXW) ? MAXW : m_wait[i] + 1);
      end
      m_rst_prev = rst;
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (obs_g[i]) rq_act[i] = 1'b0;
      drive();
   endtask

   task automatic drain();
      for (int n = 0; n < 40 && (rq_act[0] || rq_act[1] || rq_act[2]); n++) step();
      check("drain_idle", 32'({rq_act[2], rq_act[1], rq_act[0]}), 32'h0);
      step();
   endtask

`ifndef RISC16_MEM_ARB_RR_EN
   task automatic starve_run(input string tag);
      int n;
      bit hit;
      n = 0; hit = 1'b0;
      post(0, 1'b0, 16'h0011, 16'h0);
      if (!rq_act[1]) post(1, 1'b0, 16'h0021, 16'h0);
      for (int k = 0; k < 20 && !hit; k++) begin
         step();
         n++;
         if (obs_g[0]) hit = 1'b1;
         if (!rq_act[1]) post(1, 1'b0, 16'(k), 16'h0);
      end
      check(tag, 32'(n), 32'd5);
   endtask
`endif

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i]       = 16'(i) ^ 16'h5A5A;
         model_mem[i] = 16'(i) ^ 16'h5A5A;
      end
      ram[16'h0010]       = 16'hBEEF;
      model_mem[16'h0010] = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         rq_act[i] = 1'b0; rq_we[i] = 1'b0; rq_addr[i] = 16'h0; rq_wd[i] = 16'h0;
      end
      m_wait = '{0, 0, 0}; m_ptr = 0; m_owner = -1; m_rdat = 16'h0; m_rst_prev = 1'b1;
      drive();

      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      repeat (2) step();

      // Single read
      post(0, 1'b0, 16'h0010, 16'h0);
      step();
      check("sr_gnt", 32'(obs_g), 32'b001);
      step();
      check("sr_rv", 32'(obs_rv), 32'b001);
      check("sr_data", 32'(obs_rsp), 32'hBEEF);
      step();
      check("sr_rv_once", 32'(obs_rv), 32'b000);

      // Three simultaneous requests
      post(0, 1'b0, 16'h0010, 16'h0);
      post(1, 1'b0, 16'h0020, 16'h0);
      post(2, 1'b1, 16'h0030, 16'h1234);
`ifdef RISC16_MEM_ARB_RR_EN
      step(); check("pri_1", 32'(obs_g), 32'b010);
      step(); check("pri_2", 32'(obs_g), 32'b100); check("pri_rv1", 32'(obs_rv), 32'b010);
      step(); check("pri_3", 32'(obs_g), 32'b001); check("pri_rv2", 32'(obs_rv), 32'b000);
      step(); check("pri_rv3", 32'(obs_rv), 32'b001);
`else
      step(); check("pri_1", 32'(obs_g), 32'b100);
      step(); check("pri_2", 32'(obs_g), 32'b010); check("pri_rv1", 32'(obs_rv), 32'b000);
      step(); check("pri_3", 32'(obs_g), 32'b001); check("pri_rv2", 32'(obs_rv), 32'b010);
      step(); check("pri_rv3", 32'(obs_rv), 32'b001);
`endif
      check("pri_mem", 32'(ram[16'h0030]), 32'h1234);

`ifndef RISC16_MEM_ARB_RR_EN
      // Starvation, twice to show the counter restarts from zero
      starve_run("starve_n1");
      starve_run("starve_n2");
      drain();
`endif

      // Write then read of the same word on consecutive cycles
      post(1, 1'b1, 16'h0040, 16'hA5A5);
      step();
      check("wtr_wgnt", 32'(obs_g), 32'b010);
      post(0, 1'b0, 16'h0040, 16'h0);
      step();
      step();
      check("wtr_rv", 32'(obs_rv), 32'b001);
      check("wtr_data", 32'(obs_rsp), 32'hA5A5);

      // Reset arriving with a read request
      post(0, 1'b0, 16'h0010, 16'h0);
      rst = 1'b1;
      step();
      check("rst_gnt", 32'(obs_g), 32'b000);
      rst = 1'b0;
      step();
      check("rst_gnt2", 32'(obs_g), 32'b000);
      check("rst_rv", 32'(obs_rv), 32'b000);
      step();
      check("rst_serve", 32'(obs_g), 32'b001);
      step();
      check("rst_data", 32'(obs_rsp), 32'hBEEF);

`ifdef RISC16_MEM_ARB_RR_EN
      // Continuous contention right after reset: DM, LD, IF, ...
      rst = 1'b1; step(); rst = 1'b0; step();
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 3; i++) if (!rq_act[i]) post(i, 1'b0, 16'(k + 8 * i), 16'h0);
         step();
         check("rr_seq", 32'(obs_g), (k % 3 == 0) ? 32'b010 : ((k % 3 == 1) ? 32'b100 : 32'b001));
      end
      drain();
`endif

      // Random traffic with occasional resets
      for (int c = 0; c < 2500; c++) begin
         for (int i = 0; i < 3; i++)
            if (!rq_act[i] && $urandom_range(0, 99) < 50)
               post(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/risc16_mem_arbiter.md
Name: risc16_mem_arbiter

Overview:
- Shares one single-port synchronous 16-bit RAM between three requesters: instruction fetch (IF, read-only), data access (DM, read/write) and the external program loader (LD, read/write).
- Sits between the RISC16 core memory ports, the loader, and the unified RAM macro.
- Issues at most one RAM command per cycle. A read returns data one cycle after its grant.

Parameters:
- P_ADDR_W, 16, RAM word-address width.
- P_DATA_W, 16, data word width.
- P_MAX_WAIT, 8, consecutive denied cycles after which a starved requester is force-granted (fixed-priority mode only); range 1..255.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_if_req  in  1  fetch request
- i_if_addr  in  P_ADDR_W  fetch address
- o_if_gnt  out  1  fetch accepted this cycle
- o_if_rvalid  out  1  fetch data valid on o_rsp_data
- i_dm_req  in  1  data request
- i_dm_we  in  1  1=write, 0=read
- i_dm_addr  in  P_ADDR_W  data address
- i_dm_wdata  in  P_DATA_W  data write value
- o_dm_gnt  out  1  data accepted this cycle
- o_dm_rvalid  out  1  data read valid
- i_ld_req  in  1  loader request
- i_ld_we  in  1  loader write enable
- i_ld_addr  in  P_ADDR_W  loader address
- i_ld_wdata  in  P_DATA_W  loader write value
- o_ld_gnt  out  1  loader accepted
- o_ld_rvalid  out  1  loader read valid
- o_rsp_data  out  P_DATA_W  shared read-data bus
- o_ram_en  out  1  RAM command valid
- o_ram_we  out  1  RAM write strobe
- o_ram_addr  out  P_ADDR_W  RAM address
- o_ram_wdata  out  P_DATA_W  RAM write data
- i_ram_rdata  in  P_DATA_W  RAM read data, valid the cycle after o_ram_en with o_ram_we=0

Behaviour:
- Handshake:
  - A requester raises req with a stable payload and holds both until it sees gnt high on a rising edge.
  - Dropping req before gnt is illegal.
- Grant and RAM command:
  - gnt is combinational from req and arbiter state. At most one gnt is high per cycle.
  - o_ram_en/we/addr/wdata come combinationally from the granted requester.
  - With no grant, o_ram_en=0, o_ram_we=0, and addr/wdata are 0.
  - For IF, o_ram_we is always 0.
- Read response:
  - Registered: a 2-bit resp_owner (NONE/IF/DM/LD) is captured at a read grant.
  - Next cycle, the owner's rvalid pulses for one cycle and o_rsp_data = i_ram_rdata.
  - o_rsp_data is 0 when no rvalid is high.
  - Writes produce no rvalid.
- Throughput: back-to-back grants are allowed every cycle. A read response and a new grant overlap freely.
- Fixed priority (default): LD > DM > IF.
- Starvation counters:
  - Each requester has an 8-bit wait counter. It increments each cycle its req is high without gnt, and clears on gnt or when req is low.
  - When a counter reaches P_MAX_WAIT, that requester wins next regardless of priority.
  - Ties among starved requesters are resolved by fixed priority.
  - The counter saturates at P_MAX_WAIT and never wraps.
- Simultaneous events: if DM writes address A in cycle n and IF reads A in cycle n+1, IF receives the new value, since the RAM is write-before-read across cycles.
- Reset:
  - Applies to resp_owner=NONE, all wait counters=0, and the round-robin pointer=IF.
  - All outputs are 0 during i_rst and in the cycle after it.
  - A read granted in the cycle i_rst rises produces no rvalid.
  - Grants are suppressed while i_rst=1.

Optional Feature:
- Macro: RISC16_MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration; the starvation counters and P_MAX_WAIT are compiled out.
  - A 2-bit pointer names the last granted requester. Search order starts at the next requester in the ring IF→DM→LD→IF.
  - The pointer updates only on a grant.
- Undefined: fixed priority with starvation counters, as in Behaviour.

Decomposition:
- Package risc16_mem_pkg holds:
  - requester-ID localparams: REQ_NONE=0, REQ_IF=1, REQ_DM=2, REQ_LD=3;
  - default widths (16/16).
- Sub-module risc16_arb_pick: combinational 3-way request vector plus state → one-hot grant. It has two variants under the macro: fixed priority with starved-override, and round-robin from pointer. The top level owns the registers, the RAM mux and the response logic.

Test Plan:
- Single read:
  - Stimulus: RAM[0x0010]=0xBEEF; IF req addr 0x0010.
  - Response: o_if_gnt same cycle; o_if_rvalid=1 and o_rsp_data=0xBEEF next cycle only.
- Priority:
  - Stimulus: IF, DM-read 0x20 and LD-write 0x30←0x1234 asserted together.
  - Response: grants in cycles LD, DM, IF; RAM[0x30]=0x1234; rvalids only for DM then IF.
- Starvation:
  - Stimulus: P_MAX_WAIT=4; DM requests every cycle; IF holds req.
  - Response: IF granted on its 5th requesting cycle; wait counter back to 0.
- Write-then-read:
  - Stimulus: DM writes 0x40←0xA5A5 in cycle n; IF reads 0x40 in cycle n+1.
  - Response: IF returns 0xA5A5.
- Reset mid-read:
  - Stimulus: IF read granted in the same cycle i_rst=1.
  - Response: no rvalid afterwards; all outputs 0; first post-reset request served normally.
- RR build (macro defined):
  - Stimulus: all three requesters continuously requesting.
  - Response: grant sequence DM, LD, IF, DM, … after reset (pointer=IF).
